riscv_trap_ctrl: RTL and testbench

//  Trap/MRET sequencer and sole arbiter of the M-mode CSR register file's single read/write port.
//  In IDLE, passes pipeline CSR accesses straight through.
//  On an exception, interrupt or MRET, takes the port, updates the CSRs in a fixed cycle sequence, then redirects fetch.

---
 rtl/riscv_trap_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_riscv_trap_ctrl.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_trap_ctrl.sv
// Trap/MRET sequencer and sole owner of the M-mode CSR file's single read/write port.
// Passes pipeline CSR traffic through while idle; runs fixed CSR update sequences otherwise.
module riscv_trap_ctrl #(
    parameter bit          VECTORED_EN = 1'b1,
    parameter logic [11:0] NOP_ADDR    = 12'h000
) (
    input  logic        clk,
    input  logic        srst_n,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    output logic        exc_ack_o,
    input  logic        mret_valid_i,
    output logic        mret_ack_o,
    input  logic [31:0] irq_pending_i,
    input  logic        irq_ok_i,
    input  logic [31:0] irq_pc_i,
    input  logic        pipe_csr_re_i,
    input  logic [11:0] pipe_csr_raddr_i,
    output logic [31:0] pipe_csr_rdata_o,
    input  logic        pipe_csr_we_i,
    input  logic [11:0] pipe_csr_waddr_i,
    input  logic [31:0] pipe_csr_wdata_i,
    output logic        pipe_csr_stall_o,
    output logic [11:0] csr_raddr_o,
    input  logic [31:0] csr_rdata_i,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMtvec   = 12'h305;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;
    localparam logic [11:0] CsrMtval   = 12'h343;

    typedef enum logic [3:0] {
        StIdle,
        StTEpc,
        StTCause,
        StTTval,
        StTStatus,
        StTRedir,
        StMRd,
        StMWr,
        StMRedir
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        r_mie;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic [31:0] r_tval;
    logic [31:0] r_st;
    logic [31:0] r_tvec;

    logic        w_idle;
    logic        w_irq_hit;
    logic [4:0]  w_irq_idx;
    logic        w_acc_exc;
    logic        w_acc_mret;
    logic        w_acc_irq;
    logic [31:0] w_st_trap;
    logic [31:0] w_st_mret;
    logic [31:0] w_trap_pc;
    logic        w_unused;

    assign w_unused = ^{irq_pending_i[31:12], irq_pending_i[10:8], irq_pending_i[6:4],
                        irq_pending_i[2:0]};

    // Gating with srst_n keeps every pulse and write quiet while reset is held.
    assign w_idle     = (r_state == StIdle) & srst_n;
    assign w_irq_hit  = r_mie & irq_ok_i & (irq_pending_i[11] | irq_pending_i[3] | irq_pending_i[7]);
    assign w_irq_idx  = irq_pending_i[11] ? 5'd11 : (irq_pending_i[3] ? 5'd3 : 5'd7);
    assign w_acc_exc  = w_idle & exc_valid_i;
    assign w_acc_mret = w_idle & ~exc_valid_i & mret_valid_i;
    assign w_acc_irq  = w_idle & ~exc_valid_i & ~mret_valid_i & w_irq_hit;

    assign exc_ack_o  = w_acc_exc;
    assign mret_ack_o = w_acc_mret;
    assign flush_o    = w_acc_exc | w_acc_mret | w_acc_irq;

    always_comb begin
        w_st_trap        = r_st;
        w_st_trap[12:11] = 2'b11;
        w_st_trap[7]     = r_st[3];
        w_st_trap[3]     = 1'b0;
        w_st_mret        = r_st;
        w_st_mret[12:11] = 2'b11;
        w_st_mret[7]     = 1'b1;
        w_st_mret[3]     = r_st[7];
    end

    always_comb begin
        w_trap_pc = {r_tvec[31:2], 2'b00};
        if (VECTORED_EN && (r_tvec[1:0] == 2'b01) && r_cause[31]) begin
            w_trap_pc = w_trap_pc + {25'd0, r_cause[4:0], 2'b00};
        end
    end

    always_comb begin
        w_state_next     = r_state;
        csr_raddr_o      = NOP_ADDR;
        csr_waddr_o      = NOP_ADDR;
        csr_wdata_o      = 32'd0;
        pipe_csr_rdata_o = 32'd0;
        pipe_csr_stall_o = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'd0;
        busy_o           = 1'b1;
        unique case (r_state)
            StIdle: begin
                busy_o           = 1'b0;
                csr_raddr_o      = pipe_csr_raddr_i;
                pipe_csr_rdata_o = csr_rdata_i;
                csr_wdata_o      = pipe_csr_wdata_i;
                if (pipe_csr_we_i && srst_n) begin
                    csr_waddr_o = pipe_csr_waddr_i;
                end
                if (w_acc_exc || w_acc_irq) begin
                    w_state_next = StTEpc;
                end else if (w_acc_mret) begin
                    w_state_next = StMRd;
                end
            end
            StTEpc: begin
                csr_waddr_o  = CsrMepc;
                csr_wdata_o  = {r_epc[31:2], 2'b00};
                csr_raddr_o  = CsrMstatus;
                w_state_next = StTCause;
            end
            StTCause: begin
                csr_waddr_o  = CsrMcause;
                csr_wdata_o  = r_cause;
                w_state_next = StTTval;
            end
            StTTval: begin
                csr_waddr_o  = CsrMtval;
                csr_wdata_o  = r_tval;
                w_state_next = StTStatus;
            end
            StTStatus: begin
                csr_waddr_o  = CsrMstatus;
                csr_wdata_o  = w_st_trap;
                csr_raddr_o  = CsrMtvec;
                w_state_next = StTRedir;
            end
            StTRedir: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = w_trap_pc;
                w_state_next     = StIdle;
            end
            StMRd: begin
                csr_raddr_o  = CsrMstatus;
                w_state_next = StMWr;
            end
            StMWr: begin
                csr_waddr_o  = CsrMstatus;
                csr_wdata_o  = w_st_mret;
                csr_raddr_o  = CsrMepc;
                w_state_next = StMRedir;
            end
            StMRedir: begin
                redirect_valid_o = 1'b1;
                redirect_pc_o    = {r_epc[31:2], 2'b00};
                w_state_next     = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
        // Refused pipeline accesses are dropped; the pipeline retries them.
        if (r_state != StIdle) begin
            pipe_csr_stall_o = pipe_csr_re_i | pipe_csr_we_i;
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_state <= StIdle;
            r_mie   <= 1'b0;
            r_cause <= 32'd0;
            r_epc   <= 32'd0;
            r_tval  <= 32'd0;
            r_st    <= 32'd0;
            r_tvec  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (csr_waddr_o == CsrMstatus) begin
                r_mie <= csr_wdata_o[3];
            end
            if (w_acc_exc) begin
                r_cause <= {27'd0, exc_cause_i};
                r_epc   <= exc_pc_i;
                r_tval  <= exc_tval_i;
            end else if (w_acc_irq) begin
                r_cause <= {1'b1, 26'd0, w_irq_idx};
                r_epc   <= irq_pc_i;
                r_tval  <= 32'd0;
            end
            if (r_state == StTEpc || r_state == StMRd) begin
                r_st <= csr_rdata_i;
            end
            if (r_state == StTStatus) begin
                r_tvec <= csr_rdata_i;
            end
            if (r_state == StMWr) begin
                r_epc <= csr_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Directed bench for riscv_trap_ctrl: vectored (a) and direct (b) instances share stimulus,
// each with its own combinational-read CSR array.
module tb_riscv_trap_ctrl;

    logic        clk;
    logic        srst_n;
    logic        exc_valid_i;
    logic [4:0]  exc_cause_i;
    logic [31:0] exc_pc_i;
    logic [31:0] exc_tval_i;
    logic        mret_valid_i;
    logic [31:0] irq_pending_i;
    logic        irq_ok_i;
    logic [31:0] irq_pc_i;
    logic        pipe_csr_re_i;
    logic [11:0] pipe_csr_raddr_i;
    logic        pipe_csr_we_i;
    logic [11:0] pipe_csr_waddr_i;
    logic [31:0] pipe_csr_wdata_i;

    logic        exc_ack_a, mret_ack_a, stall_a, flush_a, redir_v_a, busy_a;
    logic [31:0] pipe_rdata_a, wdata_a, redir_pc_a, rdata_a;
    logic [11:0] raddr_a, waddr_a;
    logic        exc_ack_b, mret_ack_b, stall_b, flush_b, redir_v_b, busy_b;
    logic [31:0] pipe_rdata_b, wdata_b, redir_pc_b, rdata_b;
    logic [11:0] raddr_b, waddr_b;

    logic [31:0] rf_a [0:4095];
    logic [31:0] rf_b [0:4095];

    int n_checks;
    int n_fail;

    riscv_trap_ctrl #(.VECTORED_EN(1'b1), .NOP_ADDR(12'h000)) dut_a (
        .clk(clk), .srst_n(srst_n),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
        .exc_tval_i(exc_tval_i), .exc_ack_o(exc_ack_a),
        .mret_valid_i(mret_valid_i), .mret_ack_o(mret_ack_a),
        .irq_pending_i(irq_pending_i), .irq_ok_i(irq_ok_i), .irq_pc_i(irq_pc_i),
        .pipe_csr_re_i(pipe_csr_re_i), .pipe_csr_raddr_i(pipe_csr_raddr_i),
        .pipe_csr_rdata_o(pipe_rdata_a), .pipe_csr_we_i(pipe_csr_we_i),
        .pipe_csr_waddr_i(pipe_csr_waddr_i), .pipe_csr_wdata_i(pipe_csr_wdata_i),
        .pipe_csr_stall_o(stall_a),
        .csr_raddr_o(raddr_a), .csr_rdata_i(rdata_a), .csr_waddr_o(waddr_a),
        .csr_wdata_o(wdata_a), .flush_o(flush_a), .redirect_valid_o(redir_v_a),
        .redirect_pc_o(redir_pc_a), .busy_o(busy_a)
    );

    riscv_trap_ctrl #(.VECTORED_EN(1'b0), .NOP_ADDR(12'h000)) dut_b (
        .clk(clk), .srst_n(srst_n),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
        .exc_tval_i(exc_tval_i), .exc_ack_o(exc_ack_b),
        .mret_valid_i(mret_valid_i), .mret_ack_o(mret_ack_b),
        .irq_pending_i(irq_pending_i), .irq_ok_i(irq_ok_i), .irq_pc_i(irq_pc_i),
        .pipe_csr_re_i(pipe_csr_re_i), .pipe_csr_raddr_i(pipe_csr_raddr_i),
        .pipe_csr_rdata_o(pipe_rdata_b), .pipe_csr_we_i(pipe_csr_we_i),
        .pipe_csr_waddr_i(pipe_csr_waddr_i), .pipe_csr_wdata_i(pipe_csr_wdata_i),
        .pipe_csr_stall_o(stall_b),
        .csr_raddr_o(raddr_b), .csr_rdata_i(rdata_b), .csr_waddr_o(waddr_b),
        .csr_wdata_o(wdata_b), .flush_o(flush_b), .redirect_valid_o(redir_v_b),
        .redirect_pc_o(redir_pc_b), .busy_o(busy_b)
    );

    assign rdata_a = rf_a[raddr_a];
    assign rdata_b = rf_b[raddr_b];

    always @(posedge clk) begin
        if (waddr_a != 12'h000) rf_a[waddr_a] <= wdata_a;
        if (waddr_b != 12'h000) rf_b[waddr_b] <= wdata_b;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe_write(input logic [11:0] a, input logic [31:0] d);
        pipe_csr_we_i    = 1'b1;
        pipe_csr_waddr_i = a;
        pipe_csr_wdata_i = d;
        tick();
        pipe_csr_we_i    = 1'b0;
    endtask

    // Called one cycle after accept; n = cycles from accept to redirect, -1 if never seen.
    task automatic wait_redir(output int n);
        n = -1;
        for (int i = 2; i <= 14; i++) begin
            tick();
            if (redir_v_a) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        srst_n = 1'b0;
        exc_valid_i = 1'b1;
        pipe_csr_re_i = 1'b1;
        pipe_csr_we_i = 1'b1;
        pipe_csr_waddr_i = 12'h300;
        #2;
        n_checks++;
        if (exc_ack_a !== 1'b0 || flush_a !== 1'b0 || redir_v_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: ack/flush/redir=%b%b%b want 000", exc_ack_a, flush_a,
                     redir_v_a);
        end
        n_checks++;
        if (busy_a !== 1'b0 || stall_a !== 1'b0 || waddr_a !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b stall=%b waddr=%h want 0 0 000", busy_a, stall_a,
                     waddr_a);
        end
        exc_valid_i = 1'b0;
        pipe_csr_re_i = 1'b0;
        pipe_csr_we_i = 1'b0;
        tick();
        srst_n = 1'b1;
        tick();
    endtask

    task automatic test_exception();
        int n;
        pipe_write(12'h305, 32'h0000_8000);
        pipe_write(12'h300, 32'h0000_0008);
        exc_valid_i = 1'b1;
        exc_cause_i = 5'd2;
        exc_pc_i    = 32'h100;
        exc_tval_i  = 32'hDEAD;
        #1;
        n_checks++;
        if (exc_ack_a !== 1'b1 || flush_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_accept: ack=%b flush=%b busy=%b want 1 1 0", exc_ack_a, flush_a,
                     busy_a);
        end
        tick();
        exc_valid_i = 1'b0;
        n_checks++;
        if (busy_a !== 1'b1 || exc_ack_a !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_busy: busy=%b ack=%b want 1 0", busy_a, exc_ack_a);
        end
        wait_redir(n);
        n_checks++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL exc_latency: got %0d want 5", n);
        end
        n_checks++;
        if (redir_pc_a !== 32'h8000 || redir_pc_b !== 32'h8000) begin
            n_fail++;
            $display("FAIL exc_pc: a=%h b=%h want 00008000", redir_pc_a, redir_pc_b);
        end
        n_checks++;
        if (rf_a[12'h341] !== 32'h100 || rf_a[12'h342] !== 32'h2 || rf_a[12'h343] !== 32'hDEAD
            || rf_a[12'h300] !== 32'h1880) begin
            n_fail++;
            $display("FAIL exc_csrs: epc=%h cause=%h tval=%h st=%h want 100 2 dead 1880",
                     rf_a[12'h341], rf_a[12'h342], rf_a[12'h343], rf_a[12'h300]);
        end
        tick();
    endtask

    task automatic test_mret();
        int n;
        mret_valid_i = 1'b1;
        #1;
        n_checks++;
        if (mret_ack_a !== 1'b1 || flush_a !== 1'b1) begin
            n_fail++;
            $display("FAIL mret_accept: ack=%b flush=%b want 1 1", mret_ack_a, flush_a);
        end
        tick();
        mret_valid_i = 1'b0;
        wait_redir(n);
        n_checks++;
        if (n !== 3 || redir_pc_a !== 32'h100 || redir_pc_b !== 32'h100) begin
            n_fail++;
            $display("FAIL mret_redir: lat=%0d pc=%h want 3 00000100", n, redir_pc_a);
        end
        n_checks++;
        if (rf_a[12'h300] !== 32'h1888) begin
            n_fail++;
            $display("FAIL mret_status: got %h want 00001888", rf_a[12'h300]);
        end
        tick();
    endtask

    task automatic test_irq_vectored();
        int n;
        pipe_write(12'h305, 32'h0000_8001);
        pipe_write(12'h300, 32'h0000_0008);
        irq_ok_i      = 1'b1;
        irq_pending_i = 32'h80;
        irq_pc_i      = 32'h204;
        #1;
        n_checks++;
        if (flush_a !== 1'b1 || exc_ack_a !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_accept: flush=%b ack=%b want 1 0", flush_a, exc_ack_a);
        end
        tick();
        irq_pending_i = 32'h0;
        wait_redir(n);
        n_checks++;
        if (redir_pc_a !== 32'h801C || redir_pc_b !== 32'h8000) begin
            n_fail++;
            $display("FAIL irq_vector: vec=%h direct=%h want 0000801c 00008000", redir_pc_a,
                     redir_pc_b);
        end
        n_checks++;
        if (rf_a[12'h342] !== 32'h8000_0007 || rf_a[12'h341] !== 32'h204
            || rf_a[12'h343] !== 32'h0) begin
            n_fail++;
            $display("FAIL irq_csrs: cause=%h epc=%h tval=%h want 80000007 204 0",
                     rf_a[12'h342], rf_a[12'h341], rf_a[12'h343]);
        end
        tick();
    endtask

    task automatic test_irq_priority();
        int n;
        pipe_write(12'h300, 32'h0000_0008);
        irq_pending_i = 32'h808;
        #1;
        tick();
        irq_pending_i = 32'h0;
        wait_redir(n);
        n_checks++;
        if (rf_a[12'h342] !== 32'h8000_000B || redir_pc_a !== 32'h802C) begin
            n_fail++;
            $display("FAIL irq_prio: cause=%h pc=%h want 8000000b 0000802c", rf_a[12'h342],
                     redir_pc_a);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        pipe_write(12'h300, 32'h0);
        exc_valid_i   = 1'b1;
        exc_cause_i   = 5'd5;
        exc_pc_i      = 32'h300;
        exc_tval_i    = 32'h11;
        mret_valid_i  = 1'b1;
        irq_pending_i = 32'h8;
        #1;
        n_checks++;
        if (exc_ack_a !== 1'b1 || mret_ack_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_prio: exc_ack=%b mret_ack=%b want 1 0", exc_ack_a, mret_ack_a);
        end
        tick();
        exc_valid_i = 1'b0;
        n_checks++;
        if (mret_ack_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_mret_held: mret_ack=%b want 0", mret_ack_a);
        end
        wait_redir(n);
        tick();
        n_checks++;
        if (mret_ack_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_mret_ack: ack=%b busy=%b want 1 0", mret_ack_a, busy_a);
        end
        tick();
        mret_valid_i = 1'b0;
        wait_redir(n);
        n_checks++;
        if (n !== 3 || redir_pc_a !== 32'h300 || rf_a[12'h300] !== 32'h1880) begin
            n_fail++;
            $display("FAIL b2b_mret: lat=%0d pc=%h st=%h want 3 300 1880", n, redir_pc_a,
                     rf_a[12'h300]);
        end
        tick();
        n_checks++;
        if (flush_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_irq_masked: flush=%b busy=%b want 0 0", flush_a, busy_a);
        end
        irq_pending_i = 32'h0;
    endtask

    task automatic test_stall();
        int n;
        pipe_write(12'h340, 32'h1234);
        pipe_csr_re_i    = 1'b1;
        pipe_csr_raddr_i = 12'h340;
        #1;
        n_checks++;
        if (pipe_rdata_a !== 32'h1234 || stall_a !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_read: data=%h stall=%b want 1234 0", pipe_rdata_a, stall_a);
        end
        exc_valid_i = 1'b1;
        exc_cause_i = 5'd4;
        exc_pc_i    = 32'h600;
        exc_tval_i  = 32'h0;
        tick();
        exc_valid_i      = 1'b0;
        pipe_csr_we_i    = 1'b1;
        pipe_csr_waddr_i = 12'h340;
        pipe_csr_wdata_i = 32'h55;
        #1;
        n_checks++;
        if (stall_a !== 1'b1 || pipe_rdata_a !== 32'h0 || waddr_a !== 12'h341) begin
            n_fail++;
            $display("FAIL busy_stall: stall=%b data=%h waddr=%h want 1 0 341", stall_a,
                     pipe_rdata_a, waddr_a);
        end
        wait_redir(n);
        n_checks++;
        if (stall_a !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_stall: stall=%b want 1", stall_a);
        end
        pipe_csr_we_i = 1'b0;
        pipe_csr_re_i = 1'b0;
        tick();
        n_checks++;
        if (rf_a[12'h340] !== 32'h1234) begin
            n_fail++;
            $display("FAIL busy_drop: mscratch=%h want 1234", rf_a[12'h340]);
        end
        pipe_write(12'h300, 32'h0);
        irq_ok_i      = 1'b1;
        irq_pending_i = 32'h80;
        #1;
        n_checks++;
        if (flush_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mie_off: flush=%b want 0", flush_a);
        end
        irq_pending_i = 32'h0;
        pipe_write(12'h300, 32'h8);
        n_checks++;
        if (rf_a[12'h300] !== 32'h8) begin
            n_fail++;
            $display("FAIL idle_write: mstatus=%h want 8", rf_a[12'h300]);
        end
        irq_pending_i = 32'h80;
        #1;
        n_checks++;
        if (flush_a !== 1'b1) begin
            n_fail++;
            $display("FAIL mie_on: flush=%b want 1", flush_a);
        end
        tick();
        irq_pending_i = 32'h0;
        wait_redir(n);
        tick();
    endtask

    task automatic test_reset_midseq();
        int n;
        exc_valid_i = 1'b1;
        exc_cause_i = 5'd7;
        exc_pc_i    = 32'h400;
        exc_tval_i  = 32'h22;
        #1;
        tick();
        exc_valid_i = 1'b0;
        tick();
        srst_n        = 1'b0;
        pipe_csr_re_i = 1'b1;
        #1;
        n_checks++;
        if (busy_a !== 1'b0 || redir_v_a !== 1'b0 || stall_a !== 1'b0 || waddr_a !== 12'h000) begin
            n_fail++;
            $display("FAIL midseq_reset: busy=%b redir=%b stall=%b waddr=%h want 0 0 0 000",
                     busy_a, redir_v_a, stall_a, waddr_a);
        end
        n_checks++;
        if (rf_a[12'h341] !== 32'h400 || rf_a[12'h342] !== 32'h8000_0007) begin
            n_fail++;
            $display("FAIL midseq_csrs: epc=%h cause=%h want 400 80000007", rf_a[12'h341],
                     rf_a[12'h342]);
        end
        tick();
        srst_n        = 1'b1;
        pipe_csr_re_i = 1'b0;
        tick();
        exc_valid_i = 1'b1;
        exc_cause_i = 5'd3;
        exc_pc_i    = 32'h500;
        exc_tval_i  = 32'h33;
        #1;
        n_checks++;
        if (exc_ack_a !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ack: ack=%b want 1", exc_ack_a);
        end
        tick();
        exc_valid_i = 1'b0;
        wait_redir(n);
        n_checks++;
        if (n !== 5 || rf_a[12'h342] !== 32'h3 || rf_a[12'h341] !== 32'h500
            || rf_a[12'h343] !== 32'h33) begin
            n_fail++;
            $display("FAIL post_reset_trap: lat=%0d cause=%h epc=%h tval=%h want 5 3 500 33", n,
                     rf_a[12'h342], rf_a[12'h341], rf_a[12'h343]);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        srst_n = 1'b0;
        exc_valid_i = 1'b0;
        exc_cause_i = 5'd0;
        exc_pc_i = 32'd0;
        exc_tval_i = 32'd0;
        mret_valid_i = 1'b0;
        irq_pending_i = 32'd0;
        irq_ok_i = 1'b0;
        irq_pc_i = 32'd0;
        pipe_csr_re_i = 1'b0;
        pipe_csr_raddr_i = 12'h0;
        pipe_csr_we_i = 1'b0;
        pipe_csr_waddr_i = 12'h0;
        pipe_csr_wdata_i = 32'd0;
        test_reset();
        test_exception();
        test_mret();
        test_irq_vectored();
        test_irq_priority();
        test_back_to_back();
        test_stall();
        test_reset_midseq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
